// File: rtl/fifo_read_stage.sv
// fifo_read_stage: read side of a synchronous FIFO. It drives the FIFO read
// enable, absorbs the FIFO's one-cycle registered read latency and re-presents
// the words on a valid/ready stream. A 2-entry skid buffer plus a credit rule
// (buffered + in-flight - popped < 2) sustains one word per cycle under
// backpressure without ever overflowing or reading an empty FIFO.
// Optional feature: define FIFO_RD_STATS_EN to add the STATS_WIDTH parameter
// and the wrapping beat_count output (words delivered since reset).
module fifo_read_stage #(
    parameter int DATA_WIDTH = 8
`ifdef FIFO_RD_STATS_EN
    ,
    parameter int STATS_WIDTH = 16
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            buf_count
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0] beat_count
`endif
);

    logic [DATA_WIDTH-1:0] entry0_q, entry0_d;
    logic [DATA_WIDTH-1:0] entry1_q, entry1_d;
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [1:0]            count_q, count_d;
    logic                  inflight_q, inflight_d;
    logic                  pop;
    logic                  capture;
    logic [2:0]            outstanding;

    assign pop       = m_valid & m_ready;
    assign capture   = inflight_q & ~flush;
    assign m_valid   = (count_q != 2'd0);
    assign m_data    = head_q ? entry1_q : entry0_q;
    assign buf_count = count_q;

    // Words that will occupy the buffer after this cycle's pop, counting the
    // read already in flight; pop implies count_q >= 1, so no underflow.
    assign outstanding = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

    // Read only when a slot is guaranteed for the returning word; gated by
    // reset so the enable drops the instant reset is asserted.
    assign fifo_rd_en = reset & ~fifo_empty & ~flush & (outstanding < 3'd2);

    // Next-state for the buffer: flush wins over both capture and pop.
    always_comb begin
        entry0_d   = entry0_q;
        entry1_d   = entry1_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        inflight_d = fifo_rd_en;
        if (flush) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (capture) begin
                if (tail_q) begin
                    entry1_d = fifo_rd_data;
                end else begin
                    entry0_d = fifo_rd_data;
                end
                tail_d = ~tail_q;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
        end
    end

    // Buffer, pointers and in-flight flag; all cleared by asynchronous reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entry0_q   <= '0;
            entry1_q   <= '0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            entry0_q   <= entry0_d;
            entry1_q   <= entry1_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [STATS_WIDTH-1:0] beat_q, beat_d;

    assign beat_count = beat_q;

    // Delivered-word counter; wraps naturally and ignores flush.
    always_comb begin
        beat_d = beat_q + {{(STATS_WIDTH-1){1'b0}}, pop};
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_read_stage.sv
// Bench for fifo_read_stage: directed scenarios followed by random traffic,
// compared each cycle against a queue-based model of words read but not yet
// delivered.
`timescale 1ns/1ps
module tb_fifo_read_stage;

    localparam int DW = 8;
`ifdef FIFO_RD_STATS_EN
    localparam int SW = 4;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          m_ready = 1'b0;
    logic [DW-1:0] fifo_rd_data = '0;
    wire           fifo_rd_en;
    wire           m_valid;
    wire [DW-1:0]  m_data;
    wire [1:0]     buf_count;
`ifdef FIFO_RD_STATS_EN
    wire [SW-1:0]  beat_count;
`endif

    fifo_read_stage #(
        .DATA_WIDTH(DW)
`ifdef FIFO_RD_STATS_EN
        ,
        .STATS_WIDTH(SW)
`endif
    ) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .buf_count(buf_count)
`ifdef FIFO_RD_STATS_EN
        ,
        .beat_count(beat_count)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Environment FIFO contents and the reference model state.
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];     // words read from the FIFO and not yet delivered
    logic [DW-1:0] deliv_w[$];
    int            deliv_c[$];
    bit            rd_hist[$];
    bit            inflight_m  = 1'b0;
    bit            prev_rd_dut = 1'b0;
    bit            have_ret    = 1'b0;
    logic [DW-1:0] ret_word    = '0;
    int            cyc         = 0;
    int            beats_m     = 0;

    task automatic clear_logs();
        deliv_w.delete();
        deliv_c.delete();
        rd_hist.delete();
        cyc = 0;
    endtask

    // One clock cycle: entered and left 1 ns after a rising edge.
    task automatic step(input bit rdy, input bit fl);
        int            outst;
        int            bufexp;
        bit            vexp;
        bit            pop_m;
        bit            rd_exp;
        bit            dut_rd;
        logic [DW-1:0] w;
        m_ready      = rdy;
        flush        = fl;
        fifo_empty   = (src_q.size() == 0);
        fifo_rd_data = have_ret ? ret_word : DW'($urandom);
        #3;
        outst  = exp_q.size();
        bufexp = outst - int'(inflight_m);
        vexp   = (bufexp != 0);
        pop_m  = vexp && rdy;
        rd_exp = !fifo_empty && !fl && ((outst - int'(pop_m)) < 2);
        chk("rd_en", fifo_rd_en, rd_exp);
        chk("m_valid", m_valid, vexp);
        chk("buf_count", buf_count, bufexp);
        if (vexp) chk("m_data", m_data, exp_q[0]);
        chk("no_overflow", (buf_count == 2'd2 && prev_rd_dut), 0);
`ifdef FIFO_RD_STATS_EN
        chk("beat_count", beat_count, beats_m % (1 << SW));
`endif
        dut_rd = fifo_rd_en;
        rd_hist.push_back(dut_rd);
        w = (src_q.size() != 0) ? src_q[0] : '0;
        @(posedge clock);
        if (fl) begin
            exp_q.delete();
            inflight_m = 1'b0;
        end else begin
            if (pop_m) begin
                deliv_w.push_back(exp_q.pop_front());
                deliv_c.push_back(cyc);
                beats_m++;
            end
            if (rd_exp) exp_q.push_back(w);
            inflight_m = rd_exp;
        end
        have_ret = 1'b0;
        if (dut_rd && src_q.size() != 0) begin
            ret_word = src_q.pop_front();
            have_ret = 1'b1;
        end
        prev_rd_dut = dut_rd;
        cyc++;
        #1;
    endtask

    // Assert reset away from any edge and check outputs respond at once.
    task automatic reset_midcycle();
        reset = 1'b0;
        #1;
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_buf_count", buf_count, 0);
        chk("rst_m_data", m_data, 0);
`ifdef FIFO_RD_STATS_EN
        chk("rst_beat_count", beat_count, 0);
`endif
        exp_q.delete();
        src_q.delete();
        inflight_m  = 1'b0;
        prev_rd_dut = 1'b0;
        have_ret    = 1'b0;
        beats_m     = 0;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [DW-1:0] t2_vals[3];
        int            nrd;
        bit            fl;
        bit            rdy;
        t2_vals = '{8'h11, 8'h22, 8'h33};

        repeat (2) @(posedge clock);
        #1;
        reset_midcycle();

        // Three words, consumer always ready: no bubbles, 2-cycle latency.
        src_q = {8'h11, 8'h22, 8'h33};
        clear_logs();
        repeat (7) step(1'b1, 1'b0);
        chk("t2_count", deliv_w.size(), 3);
        for (int i = 0; i < 3 && i < deliv_w.size(); i++) begin
            chk("t2_word", deliv_w[i], t2_vals[i]);
            chk("t2_cycle", deliv_c[i], i + 2);
            chk("t2_rd_en", rd_hist[i], 1);
        end

        // Eight words under full backpressure: exactly two reads, then drain.
        clear_logs();
        for (int i = 0; i < 8; i++) src_q.push_back(DW'($urandom));
        repeat (6) step(1'b0, 1'b0);
        nrd = 0;
        foreach (rd_hist[i]) nrd += int'(rd_hist[i]);
        chk("t3_reads", nrd, 2);
        chk("t3_buf_full", buf_count, 2);
        repeat (14) step(1'b1, 1'b0);
        chk("t3_out", deliv_w.size(), 8);

        // Alternating ready.
        clear_logs();
        for (int i = 0; i < 10; i++) src_q.push_back(DW'($urandom));
        for (int i = 0; i < 30; i++) step(bit'(i % 2 == 0), 1'b0);
        chk("t4_out", deliv_w.size(), 10);

        // Reset with a full buffer.
        for (int i = 0; i < 6; i++) src_q.push_back(DW'($urandom));
        repeat (5) step(1'b0, 1'b0);
        chk("t1_pre_buf", buf_count, 2);
        reset_midcycle();

        // Flush the cycle after a read: the returning word is dropped.
        clear_logs();
        src_q = {8'hA5, 8'hB6, 8'hC7};
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("t5_valid_after_flush", m_valid, 0);
        repeat (6) step(1'b1, 1'b0);
        chk("t5_count", deliv_w.size(), 2);
        if (deliv_w.size() > 0) chk("t5_first", deliv_w[0], 8'hB6);

`ifdef FIFO_RD_STATS_EN
        // Counter wrap after 17 pops, untouched by flush.
        reset_midcycle();
        clear_logs();
        for (int i = 0; i < 20; i++) src_q.push_back(DW'($urandom));
        for (int k = 0; k < 100 && deliv_w.size() < 17; k++) step(1'b1, 1'b0);
        chk("t6_pops", deliv_w.size(), 17);
        chk("t6_wrap", beat_count, 1);
        step(1'b0, 1'b1);
        chk("t6_flush_keep", beat_count, 1);
`endif

        // Random traffic with occasional flushes and one reset.
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) reset_midcycle();
            if ($urandom % 3 != 0 && src_q.size() < 16) src_q.push_back(DW'($urandom));
            fl  = ($urandom % 40 == 0);
            rdy = !fl && ($urandom % 4 != 0);
            step(rdy, fl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
